// File: rtl/spi_mem_host.sv
// SPI mode-0 master issuing single-lane memory write/read frames (cmd, addr, dummy, data).
// One request per frame through a valid/ready port; read data returns on a one-cycle strobe.
module spi_mem_host #(
    parameter int unsigned CLK_DIV      = 2,
    parameter int unsigned DUMMY_CYCLES = 32,
    parameter logic [7:0]  WR_CMD       = 8'h02,
    parameter logic [7:0]  RD_CMD       = 8'h0B,
    parameter int unsigned CS_GAP       = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        busy_o,
    output logic        spi_sclk_o,
    output logic        spi_cs_o,
    output logic        spi_sdo_o,
    input  logic        spi_sdi_i
);

    localparam int unsigned   DivW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
    localparam logic [DivW-1:0] DivOne  = DivW'(1);
    localparam logic [6:0]    DummyLast = 7'(DUMMY_CYCLES - 1);
    localparam logic [6:0]    GapLast   = 7'(CS_GAP - 1);

    typedef enum logic [3:0] {
        StIdle, StCsSetup, StCmd, StAddr, StDummy, StRdata, StWdata, StCsHold, StGap
    } state_e;

    state_e            state_q;
    logic [DivW-1:0]   div_q;
    logic [6:0]        bit_q;
    logic              sclk_q;
    logic              cs_q;
    logic              ready_q;
    logic              busy_q;
    logic              rsp_valid_q;
    logic [31:0]       rdata_q;
    logic [31:0]       rx_q;
    logic [31:0]       tx_q;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic              we_q;

    logic              div_last;
    logic              bit_last;
    state_e            next_shift;
    logic [31:0]       next_tx;

    always_comb begin
        div_last = (div_q == DivLast);
        unique case (state_q)
            StCmd:   bit_last = (bit_q == 7'd7);
            StDummy: bit_last = (bit_q == DummyLast);
            default: bit_last = (bit_q == 7'd31);
        endcase
    end

    // Field that follows the one being shifted, and the word it shifts out
    always_comb begin
        next_shift = StCsHold;
        next_tx    = 32'h0;
        unique case (state_q)
            StCmd: begin
                next_shift = StAddr;
                next_tx    = addr_q;
            end
            StAddr: begin
                if (we_q) begin
                    next_shift = StWdata;
                    next_tx    = wdata_q;
                end else begin
                    next_shift = (DUMMY_CYCLES == 0) ? StRdata : StDummy;
                end
            end
            StDummy: next_shift = StRdata;
            default: next_shift = StCsHold;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            div_q       <= '0;
            bit_q       <= '0;
            sclk_q      <= 1'b0;
            cs_q        <= 1'b1;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= 32'h0;
            rx_q        <= 32'h0;
            tx_q        <= 32'h0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            we_q        <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req_valid_i) begin
                        state_q <= StCsSetup;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        cs_q    <= 1'b0;
                        div_q   <= '0;
                        bit_q   <= '0;
                        we_q    <= req_we_i;
                        addr_q  <= req_addr_i;
                        wdata_q <= req_wdata_i;
                        tx_q    <= {req_we_i ? WR_CMD : RD_CMD, 24'h0};
                    end
                end
                StCsSetup: begin
                    if (div_last) begin
                        state_q <= StCmd;
                        div_q   <= '0;
                        bit_q   <= '0;
                    end else begin
                        div_q <= div_q + DivOne;
                    end
                end
                StCmd, StAddr, StDummy, StWdata, StRdata: begin
                    if (!div_last) begin
                        div_q <= div_q + DivOne;
                    end else begin
                        div_q <= '0;
                        if (!sclk_q) begin
                            sclk_q <= 1'b1;
                            if (state_q == StRdata) begin
                                rx_q <= {rx_q[30:0], spi_sdi_i};
                            end
                        end else begin
                            // Falling edge ends the bit; sdo moves to the next bit here
                            sclk_q <= 1'b0;
                            if (bit_last) begin
                                bit_q   <= '0;
                                state_q <= next_shift;
                                tx_q    <= next_tx;
                            end else begin
                                bit_q <= bit_q + 7'd1;
                                tx_q  <= {tx_q[30:0], 1'b0};
                            end
                        end
                    end
                end
                StCsHold: begin
                    if (div_last) begin
                        div_q       <= '0;
                        bit_q       <= '0;
                        cs_q        <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        if (!we_q) begin
                            rdata_q <= rx_q;
                        end
                        if (CS_GAP == 0) begin
                            state_q <= StIdle;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= StGap;
                        end
                    end else begin
                        div_q <= div_q + DivOne;
                    end
                end
                StGap: begin
                    if (bit_q == GapLast) begin
                        state_q <= StIdle;
                        bit_q   <= '0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        bit_q <= bit_q + 7'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign req_ready_o = ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rdata_q;
    assign busy_o      = busy_q;
    assign spi_sclk_o  = sclk_q;
    assign spi_cs_o    = cs_q;
    assign spi_sdo_o   = tx_q[31];

endmodule

// File: tb/tb_spi_mem_host.sv
// Bench for spi_mem_host: two instances (default and CLK_DIV=1/DUMMY=0) against an SPI memory
// device model, a table of directed frames, multi-cycle corner sequences and random traffic.
module tb_spi_mem_host;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid, req_we, ready, rsp_valid, busy, sclk, cs, sdo, sdi;
    logic [31:0] req_addr [2];
    logic [31:0] req_wdata [2];
    logic [31:0] rdata [2];

    always #5 clk = ~clk;

    spi_mem_host #(
        .CLK_DIV(2), .DUMMY_CYCLES(32), .WR_CMD(8'h02), .RD_CMD(8'h0B), .CS_GAP(4)
    ) u_dut_dflt (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid[0]), .req_ready_o(ready[0]), .req_we_i(req_we[0]),
        .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]),
        .rsp_valid_o(rsp_valid[0]), .rsp_rdata_o(rdata[0]), .busy_o(busy[0]),
        .spi_sclk_o(sclk[0]), .spi_cs_o(cs[0]), .spi_sdo_o(sdo[0]), .spi_sdi_i(sdi[0])
    );

    spi_mem_host #(
        .CLK_DIV(1), .DUMMY_CYCLES(0), .WR_CMD(8'h02), .RD_CMD(8'h0B), .CS_GAP(4)
    ) u_dut_fast (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid[1]), .req_ready_o(ready[1]), .req_we_i(req_we[1]),
        .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]),
        .rsp_valid_o(rsp_valid[1]), .rsp_rdata_o(rdata[1]), .busy_o(busy[1]),
        .spi_sclk_o(sclk[1]), .spi_cs_o(cs[1]), .spi_sdo_o(sdo[1]), .spi_sdi_i(sdi[1])
    );

    int n_checks = 0;
    int n_errors = 0;

    // Device model / monitor state, one slot per instance
    int          low_cnt [2], high_cnt [2], rise_cnt [2], last_high [2];
    int          frm_cnt [2], frm_len [2], frm_rises [2], rsp_cnt [2], rsp_misalign [2];
    logic [7:0]  dcmd [2], frm_cmd [2];
    logic [31:0] daddr [2], dwd [2], rsh [2], frm_addr [2], frm_wd [2], rsp_cap [2];
    bit          sdo_nz [2], frm_nz [2], cs_prev [2], sclk_prev [2];
    logic [31:0] dev_mem [logic [32:0]];
    logic [31:0] ref_mem [logic [32:0]];

    function automatic logic [32:0] mkey(input int g, input logic [31:0] a);
        return {g[0], a};
    endfunction

    // Unwritten locations read back as a fixed function of the address
    function automatic logic [31:0] dev_rd(input int g, input logic [31:0] a);
        if (dev_mem.exists(mkey(g, a))) return dev_mem[mkey(g, a)];
        return a ^ 32'hC3C3_3C3C;
    endfunction

    function automatic logic [31:0] ref_rd(input int g, input logic [31:0] a);
        if (ref_mem.exists(mkey(g, a))) return ref_mem[mkey(g, a)];
        return a ^ 32'hC3C3_3C3C;
    endfunction

    function automatic int exp_len(input int g, input bit we);
        int cd = (g == 0) ? 2 : 1;
        int dm = (g == 0) ? 32 : 0;
        return cd * (2 + 2 * (72 + (we ? 0 : dm)));
    endfunction

    initial begin
        for (int g = 0; g < 2; g++) begin
            low_cnt[g] = 0; high_cnt[g] = 0; rise_cnt[g] = 0; last_high[g] = 0;
            frm_cnt[g] = 0; frm_len[g] = 0; frm_rises[g] = 0; rsp_cnt[g] = 0;
            rsp_misalign[g] = 0; dcmd[g] = 0; frm_cmd[g] = 0; daddr[g] = 0; dwd[g] = 0;
            rsh[g] = 0; frm_addr[g] = 0; frm_wd[g] = 0; rsp_cap[g] = 0; sdo_nz[g] = 0;
            frm_nz[g] = 0; cs_prev[g] = 1; sclk_prev[g] = 0;
        end
        sdi = '0;
        forever begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                if (cs[g] && !cs_prev[g]) begin
                    frm_len[g] = low_cnt[g]; frm_rises[g] = rise_cnt[g];
                    frm_cmd[g] = dcmd[g]; frm_addr[g] = daddr[g]; frm_wd[g] = dwd[g];
                    frm_nz[g] = sdo_nz[g]; frm_cnt[g]++;
                    if (dcmd[g] == 8'h02 && rise_cnt[g] == 72) dev_mem[mkey(g, daddr[g])] = dwd[g];
                    high_cnt[g] = 0;
                end
                if (!cs[g] && cs_prev[g]) begin
                    last_high[g] = high_cnt[g]; low_cnt[g] = 0; rise_cnt[g] = 0;
                    sdo_nz[g] = 0; dcmd[g] = 0; daddr[g] = 0; dwd[g] = 0;
                end
                if (cs[g]) high_cnt[g]++; else low_cnt[g]++;
                if (!cs[g] && sclk[g] && !sclk_prev[g]) begin
                    if (rise_cnt[g] < 8) dcmd[g] = {dcmd[g][6:0], sdo[g]};
                    else if (rise_cnt[g] < 40) daddr[g] = {daddr[g][30:0], sdo[g]};
                    else if (dcmd[g] == 8'h02) dwd[g] = {dwd[g][30:0], sdo[g]};
                    else if (sdo[g]) sdo_nz[g] = 1;
                    rise_cnt[g]++;
                    if (rise_cnt[g] == 40) rsh[g] = dev_rd(g, daddr[g]);
                end
                if (!cs[g] && !sclk[g] && sclk_prev[g] && dcmd[g] == 8'h0B &&
                    rise_cnt[g] >= 40 + ((g == 0) ? 32 : 0) &&
                    rise_cnt[g] < 72 + ((g == 0) ? 32 : 0)) begin
                    sdi[g] = rsh[g][31];
                    rsh[g] = {rsh[g][30:0], 1'b0};
                end
                if (rsp_valid[g]) begin
                    rsp_cnt[g]++; rsp_cap[g] = rdata[g];
                    if (!(cs[g] && !cs_prev[g])) rsp_misalign[g]++;
                end
                cs_prev[g] = cs[g]; sclk_prev[g] = sclk[g];
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input int g);
        int t = 0;
        while (!ready[g] && t < 3000) begin step(); t++; end
        chk("ready_wait", 32'(ready[g]), 32'd1);
    endtask

    task automatic wait_frame(input int g, input int f0);
        int t = 0;
        while (frm_cnt[g] == f0 && t < 3000) begin step(); t++; end
        chk("frame_done", 32'(frm_cnt[g] - f0), 32'd1);
    endtask

    // One request; inputs are scrambled right after acceptance
    task automatic xact(input int g, input bit we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input int elen);
        int f0, r0;
        logic [31:0] prev_rd;
        wait_ready(g);
        prev_rd = rdata[g]; f0 = frm_cnt[g]; r0 = rsp_cnt[g];
        req_we[g] = we; req_addr[g] = a; req_wdata[g] = wd; req_valid[g] = 1'b1;
        step();
        req_valid[g] = 1'b0; req_we[g] = ~we; req_addr[g] = ~a; req_wdata[g] = $urandom;
        chk("busy_after_accept", 32'(busy[g]), 32'd1);
        chk("ready_after_accept", 32'(ready[g]), 32'd0);
        wait_frame(g, f0);
        step(); step();
        chk("rsp_count", 32'(rsp_cnt[g] - r0), 32'd1);
        chk("rsp_align", 32'(rsp_misalign[g]), 32'd0);
        chk("cmd", 32'(frm_cmd[g]), we ? 32'h02 : 32'h0B);
        chk("addr", frm_addr[g], a);
        chk("cs_low_len", 32'(frm_len[g]), 32'(elen));
        chk("sclk_rises", 32'(frm_rises[g]), we ? 32'd72 : 32'(72 + ((g == 0) ? 32 : 0)));
        if (we) begin
            chk("wdata", frm_wd[g], wd);
            chk("rdata_held", rdata[g], prev_rd);
        end else begin
            chk("sdo_zero_in_read", 32'(frm_nz[g]), 32'd0);
            chk("rsp_rdata", rsp_cap[g], exp_rd);
            chk("rdata_hold", rdata[g], exp_rd);
        end
    endtask

    typedef struct {
        int          g;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        int          exp_len;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int f0, n, r0, t;
        vecs[0] = '{0, 1'b1, 32'h0000_0064, 32'h0000_0064, 32'h0,         292};
        vecs[1] = '{0, 1'b0, 32'h0000_0064, 32'h0,         32'h0000_0064, 420};
        vecs[2] = '{0, 1'b1, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'h0,         292};
        vecs[3] = '{0, 1'b0, 32'hDEAD_BEEF, 32'h0,         32'hFFFF_FFFF, 420};
        vecs[4] = '{1, 1'b1, 32'h0000_0010, 32'hA5A5_5A5A, 32'h0,         146};
        vecs[5] = '{1, 1'b0, 32'h0000_0010, 32'h0,         32'hA5A5_5A5A, 146};
        vecs[6] = '{0, 1'b0, 32'h0000_0000, 32'h0,         32'hC3C3_3C3C, 420};

        req_valid = '0; req_we = '0;
        for (int g = 0; g < 2; g++) begin req_addr[g] = '0; req_wdata[g] = '0; end
        repeat (3) step();
        for (int g = 0; g < 2; g++) begin
            chk("rst_ready", 32'(ready[g]), 32'd1);
            chk("rst_rsp_valid", 32'(rsp_valid[g]), 32'd0);
            chk("rst_rdata", rdata[g], 32'h0);
            chk("rst_busy", 32'(busy[g]), 32'd0);
            chk("rst_sclk", 32'(sclk[g]), 32'd0);
            chk("rst_cs", 32'(cs[g]), 32'd1);
            chk("rst_sdo", 32'(sdo[g]), 32'd0);
        end
        rst = 1'b0;
        step();

        for (int i = 0; i < 7; i++) begin
            xact(vecs[i].g, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd,
                 vecs[i].exp_len);
            if (vecs[i].we) ref_mem[mkey(vecs[i].g, vecs[i].addr)] = vecs[i].wdata;
        end

        // Back-to-back writes with req_valid held high
        wait_ready(0);
        f0 = frm_cnt[0];
        req_we[0] = 1'b1; req_addr[0] = 32'h0000_0200; req_wdata[0] = 32'h1111_2222;
        req_valid[0] = 1'b1;
        step();
        req_addr[0] = 32'h0000_0204; req_wdata[0] = 32'h3333_4444;
        wait_frame(0, f0);
        chk("b2b_addr1", frm_addr[0], 32'h0000_0200);
        chk("b2b_data1", frm_wd[0], 32'h1111_2222);
        n = 0;
        while (!ready[0] && n < 50) begin step(); n++; end
        chk("b2b_ready_gap", 32'(n), 32'd4);
        step();
        chk("b2b_accept2", 32'(busy[0]), 32'd1);
        req_valid[0] = 1'b0;
        wait_frame(0, f0 + 1);
        chk("b2b_addr2", frm_addr[0], 32'h0000_0204);
        chk("b2b_data2", frm_wd[0], 32'h3333_4444);
        chk("b2b_cs_high_min", 32'(last_high[0] >= 4), 32'd1);
        ref_mem[mkey(0, 32'h0000_0200)] = 32'h1111_2222;
        ref_mem[mkey(0, 32'h0000_0204)] = 32'h3333_4444;

        // Reset during ADDR bit 20 of a read
        wait_ready(0);
        req_we[0] = 1'b0; req_addr[0] = 32'h0000_0064; req_valid[0] = 1'b1;
        step();
        req_valid[0] = 1'b0;
        r0 = rsp_cnt[0];
        t = 0;
        while (rise_cnt[0] != 28 && t < 3000) begin step(); t++; end
        chk("rst_reached_addr20", 32'(rise_cnt[0]), 32'd28);
        rst = 1'b1;
        step();
        chk("abort_cs", 32'(cs[0]), 32'd1);
        chk("abort_sclk", 32'(sclk[0]), 32'd0);
        chk("abort_ready", 32'(ready[0]), 32'd1);
        chk("abort_busy", 32'(busy[0]), 32'd0);
        rst = 1'b0;
        step();
        chk("abort_ready_after_release", 32'(ready[0]), 32'd1);
        repeat (4) step();
        chk("abort_no_rsp", 32'(rsp_cnt[0] - r0), 32'd0);
        xact(0, 1'b0, 32'h0000_0064, 32'h0, ref_rd(0, 32'h0000_0064), exp_len(0, 1'b0));

        // Random traffic against the reference memory
        for (int i = 0; i < 16; i++) begin
            int          g;
            bit          we;
            logic [31:0] a, wd;
            logic [31:0] pool [5];
            pool = '{32'h0000_0064, 32'hDEAD_BEEF, 32'h0000_0010, 32'h0000_0004, $urandom};
            g  = int'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            a  = pool[$urandom_range(0, 4)];
            wd = $urandom;
            xact(g, we, a, wd, ref_rd(g, a), exp_len(g, we));
            if (we) ref_mem[mkey(g, a)] = wd;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
